// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the CPU load/store
// path and a host/debug port. Grants are registered and handed out round-robin.
// A requester may lock the memory for a bounded run of cycles while the other
// side waits. Memory controls are steered from whichever port holds the grant.
module dmem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_LOCK = 4,
  parameter int CW       = 16
) (
  input  logic          clk,
  input  logic          rstd,

  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic          cpu_lock,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,

  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic          dbg_lock,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_ack,
  output logic [DW-1:0] dbg_rdata,

  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_wren,
  input  logic [DW-1:0] mem_rdata,

  output logic [CW-1:0] wait_cnt
);

  localparam int LCW = $clog2(MAX_LOCK) + 1;
  // Highest value lock_cnt may reach; once there, a contended lock gives way.
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(MAX_LOCK - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CPU  = 2'd1,
    S_DBG  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           last_dbg_q, last_dbg_d;
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
  logic [CW-1:0]  wait_cnt_q, wait_cnt_d;
  logic           wr_now;

  // Grants and acks come straight from the registered owner, so the reset
  // value of the state forces every output to its idle value at once.
  assign cpu_gnt = (state_q == S_CPU);
  assign dbg_gnt = (state_q == S_DBG);
  assign cpu_ack = cpu_gnt & cpu_req;
  assign dbg_ack = dbg_gnt & dbg_req;

  assign cpu_rdata = cpu_gnt ? mem_rdata : '0;
  assign dbg_rdata = dbg_gnt ? mem_rdata : '0;

  assign mem_wren = ~wr_now;
  assign wait_cnt = wait_cnt_q;

  // Steer address/data/write strobe from the owner; the idle bus is all zeros.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    wr_now    = 1'b0;
    case (state_q)
      S_CPU: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        wr_now    = cpu_ack & cpu_we;
      end
      S_DBG: begin
        mem_addr  = dbg_addr;
        mem_wdata = dbg_wdata;
        wr_now    = dbg_ack & dbg_we;
      end
      default: begin
        mem_addr  = '0;
        mem_wdata = '0;
        wr_now    = 1'b0;
      end
    endcase
  end

  // Arbitration: pick the next owner, the lock run length and the tie-break.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = '0;
    last_dbg_d = last_dbg_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_req && dbg_req) begin
          state_d = last_dbg_q ? S_CPU : S_DBG;
        end else if (cpu_req) begin
          state_d = S_CPU;
        end else if (dbg_req) begin
          state_d = S_DBG;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CPU: begin
        if (cpu_req && cpu_lock && (lock_cnt_q < LOCK_LAST)) begin
          state_d    = S_CPU;
          lock_cnt_d = lock_cnt_q + 1'b1;
        end else if (dbg_req) begin
          state_d = S_DBG;
        end else if (cpu_req) begin
          // Uncontended: a held lock keeps its saturated count, otherwise clear.
          state_d    = S_CPU;
          lock_cnt_d = cpu_lock ? lock_cnt_q : '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DBG: begin
        if (dbg_req && dbg_lock && (lock_cnt_q < LOCK_LAST)) begin
          state_d    = S_DBG;
          lock_cnt_d = lock_cnt_q + 1'b1;
        end else if (cpu_req) begin
          state_d = S_CPU;
        end else if (dbg_req) begin
          state_d    = S_DBG;
          lock_cnt_d = dbg_lock ? lock_cnt_q : '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Remember who was served last so the next tie goes to the other side.
    if (state_d == S_DBG) begin
      last_dbg_d = 1'b1;
    end else if (state_d == S_CPU) begin
      last_dbg_d = 1'b0;
    end
  end

  // Saturating count of cycles in which someone asked and nobody was served.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if ((cpu_req | dbg_req) && !(cpu_ack | dbg_ack) && (wait_cnt_q != '1)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // State registers; CPU wins the first tie after reset.
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      state_q    <= S_IDLE;
      last_dbg_q <= 1'b1;
      lock_cnt_q <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      last_dbg_q <= last_dbg_d;
      lock_cnt_q <= lock_cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed access sequences against a behavioural
// memory, with a scoreboard of expected accesses checked on every ack.
module tb_dmem_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int MAX_LOCK = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rstd;
  logic          cpu_req, cpu_we, cpu_lock;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt, cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          dbg_req, dbg_we, dbg_lock;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_gnt, dbg_ack;
  logic [DW-1:0] dbg_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wren;
  logic [DW-1:0] mem_rdata;
  logic [CW-1:0] wait_cnt;

  logic [DW-1:0] mem [256] = '{default: 8'h00};

  typedef struct {
    logic          is_dbg;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(MAX_LOCK), .CW(CW)) dut (
    .clk(clk), .rstd(rstd),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_lock(cpu_lock),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
    .mem_rdata(mem_rdata), .wait_cnt(wait_cnt)
  );

  // Single-port memory: combinational read, write on posedge when wren is low.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_wren === 1'b0) mem[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic push(input logic d, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] dt);
    q.push_back('{d, we, a, dt});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_lock = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_lock = 0; dbg_addr = '0; dbg_wdata = '0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rstd = 0;
    step();
    step();
    rstd = 1;
  endtask

  // Monitor: every ack must match the oldest expected access.
  always @(negedge clk) begin
    if (cpu_ack === 1'b1 || dbg_ack === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: cpu_ack=%b dbg_ack=%b, expected no access (t=%0t)",
                 cpu_ack, dbg_ack, $time);
      end else begin
        e = q.pop_front();
        chk("ack_port_is_dbg", {31'd0, dbg_ack}, {31'd0, e.is_dbg});
        chk("mem_addr", {24'd0, mem_addr}, {24'd0, e.addr});
        if (e.we) begin
          chk("mem_wren_write", {31'd0, mem_wren}, 32'd0);
          chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, e.data});
        end else begin
          chk("mem_wren_read", {31'd0, mem_wren}, 32'd1);
          chk("rdata", {24'd0, (e.is_dbg ? dbg_rdata : cpu_rdata)}, {24'd0, e.data});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at t=%0t", $time);
    $fatal(1);
  end

  initial begin
    // Reset held with both requesters asking.
    idle_inputs();
    rstd = 1;
    #2 rstd = 0;
    cpu_req = 1; cpu_addr = 8'h55; cpu_we = 1; cpu_wdata = 8'h66;
    dbg_req = 1; dbg_addr = 8'h77;
    step();
    step();
    chk("rst_cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
    chk("rst_dbg_gnt", {31'd0, dbg_gnt}, 32'd0);
    chk("rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
    chk("rst_dbg_ack", {31'd0, dbg_ack}, 32'd0);
    chk("rst_mem_wren", {31'd0, mem_wren}, 32'd1);
    chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    chk("rst_cpu_rdata", {24'd0, cpu_rdata}, 32'd0);
    chk("rst_wait_cnt", {28'd0, wait_cnt}, 32'd0);

    // CPU write alone, then read back.
    reset_dut();
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h10; cpu_wdata = 8'hA5;
    push(0, 1, 8'h10, 8'hA5);
    push(0, 0, 8'h10, 8'hA5);
    step();
    chk("wr_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
    chk("wr_wait_cnt", {28'd0, wait_cnt}, 32'd1);
    step();
    cpu_we = 0; cpu_wdata = 8'h00;
    step();
    cpu_req = 0;
    #1;
    chk("drop_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
    chk("drop_cpu_ack", {31'd0, cpu_ack}, 32'd0);
    chk("drop_mem_wren", {31'd0, mem_wren}, 32'd1);
    chk("rd_wait_cnt", {28'd0, wait_cnt}, 32'd1);
    chk("mem10", {24'd0, mem[8'h10]}, 32'hA5);
    step();

    // Tie after reset: CPU first, then strict alternation.
    reset_dut();
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h30; cpu_wdata = 8'h11;
    dbg_req = 1; dbg_we = 0; dbg_addr = 8'h10;
    push(0, 1, 8'h30, 8'h11);
    push(1, 0, 8'h10, 8'hA5);
    push(0, 1, 8'h30, 8'h22);
    push(1, 0, 8'h30, 8'h22);
    step();
    step();
    cpu_wdata = 8'h22;
    step();
    dbg_addr = 8'h30;
    step();
    step();
    idle_inputs();
    step();
    chk("tie_wait_cnt", {28'd0, wait_cnt}, 32'd1);

    // Contended lock: four CPU accesses, then the debug port gets in.
    reset_dut();
    cpu_req = 1; cpu_lock = 1; cpu_we = 0; cpu_addr = 8'h30;
    dbg_req = 1; dbg_we = 1; dbg_addr = 8'h40; dbg_wdata = 8'h5A;
    for (int i = 0; i < 4; i++) push(0, 0, 8'h30, 8'h22);
    push(1, 1, 8'h40, 8'h5A);
    repeat (5) step();
    step();
    idle_inputs();
    step();
    chk("lock_wait_cnt", {28'd0, wait_cnt}, 32'd1);

    // Uncontended lock runs long, then yields at once when debug asks.
    reset_dut();
    cpu_req = 1; cpu_lock = 1; cpu_we = 0; cpu_addr = 8'h40;
    for (int i = 0; i < 13; i++) push(0, 0, 8'h40, 8'h5A);
    push(1, 1, 8'h41, 8'h77);
    repeat (13) step();
    dbg_req = 1; dbg_we = 1; dbg_addr = 8'h41; dbg_wdata = 8'h77;
    step();
    step();
    idle_inputs();
    step();
    step();
    chk("mem41", {24'd0, mem[8'h41]}, 32'h77);

    // Reset asserted while a CPU write is on the bus.
    reset_dut();
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h20; cpu_wdata = 8'h3C;
    step();
    chk("mw_setup_gnt", {31'd0, cpu_gnt}, 32'd1);
    chk("mw_setup_wren", {31'd0, mem_wren}, 32'd0);
    rstd = 0;
    #1;
    chk("mw_cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
    chk("mw_mem_wren", {31'd0, mem_wren}, 32'd1);
    chk("mw_mem_addr", {24'd0, mem_addr}, 32'd0);
    step();
    chk("mem20_unchanged", {24'd0, mem[8'h20]}, 32'h00);

    // Hand-off stall every cycle: wait_cnt climbs to 0xF and sticks.
    reset_dut();
    cpu_req = 1; cpu_addr = 8'h00;
    for (int i = 1; i <= 20; i++) begin
      step();
      chk("sat_wait_cnt", {28'd0, wait_cnt}, (i > 15) ? 32'd15 : i);
      if (i % 2 == 1) begin
        cpu_req = 0; dbg_req = 1;
      end else begin
        cpu_req = 1; dbg_req = 0;
      end
    end
    idle_inputs();
    step();
    step();

    chk("scoreboard_drained", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
